// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bundle for sync_fifo_flex: write side, read side, status flags and error clear.
// master drives requests and data; slave is the FIFO itself.
interface sync_fifo_flex_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
);
    logic             write_en;
    logic [WIDTH-1:0] write_data;
    logic             read_en;
    logic [WIDTH-1:0] read_data;
    logic             read_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNTW-1:0]  count;
    logic             overflow;
    logic             underflow;
    logic             err_clr;

    modport master (
        output write_en, write_data, read_en, err_clr,
        input  read_data, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  write_en, write_data, read_en, err_clr,
        output read_data, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock circular FIFO for any DEPTH >= 2 with occupancy count, programmable
// almost flags, standard or first-word-fall-through read, and sticky overflow/underflow.
module sync_fifo_flex #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    sync_fifo_flex_if.slave  bus
);
    localparam int ADDR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR-1:0]  wr_ptr;
    logic [ADDR-1:0]  rd_ptr;
    logic [CNTW-1:0]  count_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             full_w;
    logic             empty_w;
    logic             rd_ok;
    logic             wr_ok;

    assign full_w  = (count_q == CNTW'(DEPTH));
    assign empty_w = (count_q == '0);
    // A write into a full FIFO is still taken when the head leaves in the same cycle.
    assign rd_ok   = bus.read_en & ~empty_w;
    assign wr_ok   = bus.write_en & (~full_w | bus.read_en);

    function automatic logic [ADDR-1:0] ptr_inc(input logic [ADDR-1:0] p);
        return (p == ADDR'(DEPTH - 1)) ? '0 : p + ADDR'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset_n && wr_ok)
            mem[wr_ptr] <= bus.write_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
            // Setting takes priority over a same-cycle clear.
            if (bus.write_en && full_w && !bus.read_en)
                overflow_q <= 1'b1;
            else if (bus.err_clr)
                overflow_q <= 1'b0;
            if (bus.read_en && empty_w)
                underflow_q <= 1'b1;
            else if (bus.err_clr)
                underflow_q <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.read_data  = empty_w ? '0 : mem[rd_ptr];
            assign bus.read_valid = ~empty_w;
        end else begin : g_std
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_ok;
                    if (rd_ok)
                        rdata_q <= mem[rd_ptr];
                end
            end

            assign bus.read_data  = rdata_q;
            assign bus.read_valid = rvalid_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CNTW'(AFULL_THRESH));
    assign bus.almost_empty = (count_q <= CNTW'(AEMPTY_THRESH));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
